wasm_call_frame_ctrl: RTL and testbench
=======================================

Name: wasm_call_frame_ctrl

Overview:
- Control-stack manager directly upstream of the operand/local stack.
- On a decoded `call` it saves the caller's frame and computes the new frame base and local allocation. On `return` it restores the caller and supplies the return PC, the stack-unwind tag and the result count.
- It also translates a function-relative local index into the absolute local-memory address.

Parameters:
- FRAME_DEPTH, 16, number of saved caller frames (power of two).
- PC_W, 16, program-counter width.
- SP_W, 9, stack-pointer width (equals operand-stack log2 depth + 1).
- ROOT_LOCALS, 0, local count of the root (entry) frame.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- op_vld  in  1  decoder presents an instruction this cycle (same strobe as stack shift).
- call_req  in  1  instruction is call; qualified by op_vld.
- ret_req  in  1  instruction is return/end-of-function; qualified by op_vld.
- call_ret_pc  in  PC_W  PC to resume at after the callee returns.
- param_num  in  8  callee parameter count.
- local_num  in  8  callee non-parameter local count.
- result_num  in  1  callee result count (0 or 1).
- top_pointer  in  SP_W  current operand-stack top.
- local_idx  in  8  function-relative local index for local.get/set/tee.
- frame_ready  out  1  block accepts ops (state RUN).
- function_stack_tag  out  SP_W  current frame base, consumed on return.
- allocate_local_memory_size  out  8  equals local_num when call_req, else 0.
- l_addr  out  SP_W  cur_base + local_idx, zero-extended add.
- local_oob  out  1  local_idx >= cur_nlocals.
- ret_push_num  out  1  cur_result when ret_req, else 0.
- ret_pc  out  PC_W  registered return PC.
- ret_pc_vld  out  1  one-cycle pulse, cycle after an accepted non-root return.
- halt  out  1  sticky; return from root frame.
- trap  out  1  sticky; error condition.
- trap_code  out  2  0 none, 1 frame overflow, 2 operand underflow (top_pointer < param_num), 3 call and ret together.
- depth  out  $clog2(FRAME_DEPTH)+1  saved-frame count.

Behaviour:
- Reset (rst high at posedge) sets:
  - state RUN, depth 0, trap/halt/ret_pc_vld 0, trap_code 0, ret_pc 0.
  - cur_base 0, cur_nlocals ROOT_LOCALS, cur_result 0.
  - Frame-memory contents are don't-care.
- Reset wins over any simultaneous op. Reset mid-call discards all frames.
- States:
  - RUN: ops accepted.
  - HALT: entered on root return; the halt flag is sticky. Leave only by rst.
  - TRAP: entered on error; sticky. Leave only by rst.
  - frame_ready = (state == RUN).
- Accept = op_vld & frame_ready. Ops presented while not RUN are ignored with no state change.
- Accepted call, no error, same cycle (combinational outputs):
  - allocate_local_memory_size = local_num.
- Accepted call, at posedge:
  - mem[depth] <= {call_ret_pc, cur_base, cur_nlocals, cur_result}.
  - depth += 1.
  - cur_base <= top_pointer − param_num.
  - cur_nlocals <= param_num + local_num (9-bit sum, saturate at 255).
  - cur_result <= result_num.
- Accepted return, depth > 0, same cycle: function_stack_tag = cur_base; ret_push_num = cur_result.
- Accepted return, depth > 0, at posedge:
  - Restore cur_* from mem[depth−1]; depth −= 1.
  - ret_pc <= saved PC; ret_pc_vld = 1 for exactly one cycle.
- Accepted return at depth 0: ret_push_num/tag still driven; go HALT; no ret_pc_vld.
- Error checks on accepted ops, in priority order:
  - call & ret together → code 3.
  - call with depth == FRAME_DEPTH → code 1.
  - call with top_pointer < param_num → code 2.
- On error: go TRAP; no frame/depth change; allocate_local_memory_size = 0.
- l_addr and local_oob are purely combinational from the cur_* registers; the decoder gates its use.
- op_vld without call/ret: no state change.
- Back-to-back ops every cycle are supported; call then immediately return sees the new frame.

Decomposition:
- Shared package/header (alongside the stack width/depth defines):
  - trap-code constants.
  - state encodings.
  - frame-record field widths.
- Natural sub-module: wasm_frame_mem. It is a FRAME_DEPTH-entry synchronous-write, asynchronous-read register array holding the frame record, and carries no reset.

Test Plan:
- Root only: rst, then ret_req with op_vld → tag 0, halt=1 next cycle, ret_pc_vld stays 0, further ops ignored.
- Call from top_pointer=10 with param 2, local 3, result 1, ret PC 0x40 → alloc 3, cur_base 8, depth 1. local_idx 4 → l_addr 12, oob 0; local_idx 5 → oob 1.
- Return from that frame → tag 8, ret_push_num 1 same cycle. Next cycle ret_pc 0x40 with ret_pc_vld pulse, depth 0, cur_base 0.
- FRAME_DEPTH nested calls, then one more call → trap=1, code 1, depth stays 16, frame_ready 0.
- call with top_pointer=1, param 2 → code 2. A separate test with call and ret together → code 3; no depth change in either case.
- Reset asserted while depth 5 with a call presented → next cycle depth 0, trap/halt 0, cur_base 0, the call is dropped.

Source files
------------

// File: rtl/wasm_call_frame_ctrl_pkg.sv
// Shared types and constants for the WebAssembly call-frame controller:
// FSM encodings, trap codes and frame-record field widths.
package wasm_call_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_TRAP = 2'd2
  } state_e;

  localparam logic [1:0] TRAP_NONE      = 2'd0;
  localparam logic [1:0] TRAP_OVERFLOW  = 2'd1;
  localparam logic [1:0] TRAP_UNDERFLOW = 2'd2;
  localparam logic [1:0] TRAP_CALL_RET  = 2'd3;

  localparam int NUM_W     = 8;  // param/local/index counts
  localparam int FR_NLOC_W = 8;  // saved local count field
  localparam int FR_RES_W  = 1;  // saved result count field

  // Local counts beyond 255 cannot be addressed by an 8-bit index, so clamp.
  function automatic logic [NUM_W-1:0] sat_add8(input logic [NUM_W-1:0] a,
                                                input logic [NUM_W-1:0] b);
    logic [NUM_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[NUM_W] ? {NUM_W{1'b1}} : s[NUM_W-1:0];
  endfunction

endpackage

// File: rtl/wasm_call_frame_ctrl_if.sv
// Decoder-facing bundle of the call-frame controller.
interface wasm_call_frame_ctrl_if #(
  parameter int PC_W    = 16,
  parameter int SP_W    = 9,
  parameter int DEPTH_W = 5
);
  // op_vld is a strobe, not a held request: an op is taken exactly in a cycle
  // where op_vld and frame_ready are both high, otherwise it is dropped.
  logic               op_vld;
  logic               call_req;
  logic               ret_req;
  logic [PC_W-1:0]    call_ret_pc;
  logic [7:0]         param_num;
  logic [7:0]         local_num;
  logic               result_num;
  logic [SP_W-1:0]    top_pointer;
  logic [7:0]         local_idx;

  logic               frame_ready;
  logic [SP_W-1:0]    function_stack_tag;
  logic [7:0]         allocate_local_memory_size;
  logic [SP_W-1:0]    l_addr;
  logic               local_oob;
  logic               ret_push_num;
  logic [PC_W-1:0]    ret_pc;
  logic               ret_pc_vld;
  logic               halt;
  logic               trap;
  logic [1:0]         trap_code;
  logic [DEPTH_W-1:0] depth;

  modport master (
    output op_vld, call_req, ret_req, call_ret_pc, param_num, local_num,
           result_num, top_pointer, local_idx,
    input  frame_ready, function_stack_tag, allocate_local_memory_size,
           l_addr, local_oob, ret_push_num, ret_pc, ret_pc_vld, halt, trap,
           trap_code, depth
  );

  modport slave (
    input  op_vld, call_req, ret_req, call_ret_pc, param_num, local_num,
           result_num, top_pointer, local_idx,
    output frame_ready, function_stack_tag, allocate_local_memory_size,
           l_addr, local_oob, ret_push_num, ret_pc, ret_pc_vld, halt, trap,
           trap_code, depth
  );

endinterface

// File: rtl/wasm_frame_mem.sv
// Saved-caller frame storage: synchronous write, asynchronous read, no reset
// (entries above the live depth are never read).
module wasm_frame_mem #(
  parameter int DEPTH = 16,
  parameter int REC_W = 34,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [REC_W-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [REC_W-1:0] rdata_o
);

  logic [REC_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wasm_call_frame_ctrl.sv
// Call/return frame manager: pushes caller frames on call, restores them on
// return, and maps function-relative local indices to absolute addresses.
module wasm_call_frame_ctrl
  import wasm_call_frame_ctrl_pkg::*;
#(
  parameter int FRAME_DEPTH = 16,
  parameter int PC_W        = 16,
  parameter int SP_W        = 9,
  parameter int ROOT_LOCALS = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  wasm_call_frame_ctrl_if.slave bus,
  output state_e               dbg_state_o
);

  localparam int AW      = $clog2(FRAME_DEPTH);
  localparam int DEPTH_W = AW + 1;
  localparam int REC_W   = PC_W + SP_W + FR_NLOC_W + FR_RES_W;

  state_e               state_q, state_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic [SP_W-1:0]      cur_base_q, cur_base_d;
  logic [FR_NLOC_W-1:0] cur_nlocals_q, cur_nlocals_d;
  logic                 cur_result_q, cur_result_d;
  logic [PC_W-1:0]      ret_pc_q, ret_pc_d;
  logic                 ret_pc_vld_q, ret_pc_vld_d;
  logic [1:0]           trap_code_q, trap_code_d;

  logic                 accept;
  logic [1:0]           err_code;
  logic                 mem_we;
  logic [REC_W-1:0]     mem_wdata;
  logic [REC_W-1:0]     mem_rdata;
  logic [AW-1:0]        mem_raddr;
  logic [AW-1:0]        mem_waddr;
  logic [7:0]           alloc_size;
  logic                 ret_push;

  logic [PC_W-1:0]      rd_pc;
  logic [SP_W-1:0]      rd_base;
  logic [FR_NLOC_W-1:0] rd_nlocals;
  logic                 rd_result;

  // A call writes the slot at the current depth; a return reads the top slot.
  assign mem_waddr = depth_q[AW-1:0];
  assign mem_raddr = AW'(depth_q - DEPTH_W'(1));
  assign mem_wdata = {bus.call_ret_pc, cur_base_q, cur_nlocals_q, cur_result_q};

  assign rd_result  = mem_rdata[0];
  assign rd_nlocals = mem_rdata[FR_RES_W +: FR_NLOC_W];
  assign rd_base    = mem_rdata[FR_RES_W + FR_NLOC_W +: SP_W];
  assign rd_pc      = mem_rdata[REC_W-1 -: PC_W];

  wasm_frame_mem #(
    .DEPTH (FRAME_DEPTH),
    .REC_W (REC_W),
    .AW    (AW)
  ) u_frame_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  assign accept = bus.op_vld && (state_q == ST_RUN);

  always_comb begin
    err_code = TRAP_NONE;
    if (accept) begin
      if (bus.call_req && bus.ret_req) begin
        err_code = TRAP_CALL_RET;
      end else if (bus.call_req && (depth_q == DEPTH_W'(FRAME_DEPTH))) begin
        err_code = TRAP_OVERFLOW;
      end else if (bus.call_req && (bus.top_pointer < SP_W'(bus.param_num))) begin
        err_code = TRAP_UNDERFLOW;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    depth_d       = depth_q;
    cur_base_d    = cur_base_q;
    cur_nlocals_d = cur_nlocals_q;
    cur_result_d  = cur_result_q;
    ret_pc_d      = ret_pc_q;
    ret_pc_vld_d  = 1'b0;
    trap_code_d   = trap_code_q;
    mem_we        = 1'b0;
    alloc_size    = 8'd0;
    ret_push      = 1'b0;

    if (accept) begin
      if (err_code != TRAP_NONE) begin
        state_d     = ST_TRAP;
        trap_code_d = err_code;
      end else if (bus.call_req) begin
        mem_we        = 1'b1;
        alloc_size    = bus.local_num;
        depth_d       = depth_q + DEPTH_W'(1);
        cur_base_d    = bus.top_pointer - SP_W'(bus.param_num);
        cur_nlocals_d = sat_add8(bus.param_num, bus.local_num);
        cur_result_d  = bus.result_num;
      end else if (bus.ret_req) begin
        ret_push = cur_result_q;
        if (depth_q != '0) begin
          depth_d       = depth_q - DEPTH_W'(1);
          cur_base_d    = rd_base;
          cur_nlocals_d = rd_nlocals;
          cur_result_d  = rd_result;
          ret_pc_d      = rd_pc;
          ret_pc_vld_d  = 1'b1;
        end else begin
          // Returning from the entry frame ends the program.
          state_d = ST_HALT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      depth_q       <= '0;
      cur_base_q    <= '0;
      cur_nlocals_q <= FR_NLOC_W'(ROOT_LOCALS);
      cur_result_q  <= 1'b0;
      ret_pc_q      <= '0;
      ret_pc_vld_q  <= 1'b0;
      trap_code_q   <= TRAP_NONE;
    end else begin
      state_q       <= state_d;
      depth_q       <= depth_d;
      cur_base_q    <= cur_base_d;
      cur_nlocals_q <= cur_nlocals_d;
      cur_result_q  <= cur_result_d;
      ret_pc_q      <= ret_pc_d;
      ret_pc_vld_q  <= ret_pc_vld_d;
      trap_code_q   <= trap_code_d;
    end
  end

  assign bus.frame_ready                = (state_q == ST_RUN);
  assign bus.function_stack_tag         = cur_base_q;
  assign bus.allocate_local_memory_size = alloc_size;
  assign bus.l_addr                     = cur_base_q + SP_W'(bus.local_idx);
  assign bus.local_oob                  = (bus.local_idx >= cur_nlocals_q);
  assign bus.ret_push_num               = ret_push;
  assign bus.ret_pc                     = ret_pc_q;
  assign bus.ret_pc_vld                 = ret_pc_vld_q;
  assign bus.halt                       = (state_q == ST_HALT);
  assign bus.trap                       = (state_q == ST_TRAP);
  assign bus.trap_code                  = trap_code_q;
  assign bus.depth                      = depth_q;
  assign dbg_state_o                    = state_q;

endmodule

// File: tb/tb_wasm_call_frame_ctrl.sv
// Directed bench for wasm_call_frame_ctrl: root halt, call/return, saturation,
// overflow/underflow/conflict traps and reset during nesting.
module tb_wasm_call_frame_ctrl;
  import wasm_call_frame_ctrl_pkg::*;

  logic   clk;
  logic   rst;
  state_e dbg_state;
  int     errors = 0;
  int     checks = 0;

  wasm_call_frame_ctrl_if #(.PC_W(16), .SP_W(9), .DEPTH_W(5)) bus ();

  wasm_call_frame_ctrl #(
    .FRAME_DEPTH (16),
    .PC_W        (16),
    .SP_W        (9),
    .ROOT_LOCALS (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.op_vld      = 1'b0;
    bus.call_req    = 1'b0;
    bus.ret_req     = 1'b0;
    bus.call_ret_pc = '0;
    bus.param_num   = '0;
    bus.local_num   = '0;
    bus.result_num  = 1'b0;
    bus.top_pointer = '0;
    bus.local_idx   = '0;
  endtask

  task automatic drive_call(input logic [8:0] top, input logic [7:0] p,
                            input logic [7:0] l, input logic r, input logic [15:0] pc);
    bus.op_vld      = 1'b1;
    bus.call_req    = 1'b1;
    bus.ret_req     = 1'b0;
    bus.top_pointer = top;
    bus.param_num   = p;
    bus.local_num   = l;
    bus.result_num  = r;
    bus.call_ret_pc = pc;
    #1;
  endtask

  task automatic drive_ret();
    idle();
    bus.op_vld  = 1'b1;
    bus.ret_req = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    do_reset();

    // Reset state
    chk("rst_ready", bus.frame_ready, 1);
    chk("rst_depth", bus.depth, 0);
    chk("rst_halt", bus.halt, 0);
    chk("rst_trap", bus.trap, 0);
    chk("rst_code", bus.trap_code, 0);
    chk("rst_ret_pc", bus.ret_pc, 0);
    chk("rst_ret_vld", bus.ret_pc_vld, 0);
    chk("rst_tag", bus.function_stack_tag, 0);
    chk("rst_oob_root", bus.local_oob, 1);
    chk("rst_state", dbg_state, ST_RUN);

    // Return from root frame halts
    drive_ret();
    chk("root_tag", bus.function_stack_tag, 0);
    chk("root_push", bus.ret_push_num, 0);
    tick();
    idle();
    #1;
    chk("root_halt", bus.halt, 1);
    chk("root_ready", bus.frame_ready, 0);
    chk("root_ret_vld", bus.ret_pc_vld, 0);
    chk("root_state", dbg_state, ST_HALT);
    drive_call(9'd10, 8'd0, 8'd5, 1'b0, 16'h0011);
    chk("halt_alloc_ign", bus.allocate_local_memory_size, 0);
    tick();
    idle();
    #1;
    chk("halt_depth_ign", bus.depth, 0);
    chk("halt_sticky", bus.halt, 1);

    // Basic call and local addressing
    do_reset();
    drive_call(9'd10, 8'd2, 8'd3, 1'b1, 16'h0040);
    chk("call_alloc", bus.allocate_local_memory_size, 3);
    tick();
    idle();
    bus.local_idx = 8'd4;
    #1;
    chk("call_depth", bus.depth, 1);
    chk("call_base", bus.function_stack_tag, 8);
    chk("laddr_4", bus.l_addr, 12);
    chk("oob_4", bus.local_oob, 0);
    bus.local_idx = 8'd5;
    #1;
    chk("laddr_5", bus.l_addr, 13);
    chk("oob_5", bus.local_oob, 1);
    chk("idle_alloc", bus.allocate_local_memory_size, 0);

    // Return from that frame
    drive_ret();
    chk("ret_tag", bus.function_stack_tag, 8);
    chk("ret_push", bus.ret_push_num, 1);
    tick();
    idle();
    #1;
    chk("ret_pc", bus.ret_pc, 16'h0040);
    chk("ret_vld", bus.ret_pc_vld, 1);
    chk("ret_depth", bus.depth, 0);
    chk("ret_base", bus.function_stack_tag, 0);
    tick();
    chk("ret_vld_pulse", bus.ret_pc_vld, 0);
    chk("ret_pc_hold", bus.ret_pc, 16'h0040);

    // Call then immediate return sees the new frame
    drive_call(9'd20, 8'd1, 8'd0, 1'b0, 16'h0123);
    tick();
    drive_ret();
    chk("b2b_tag", bus.function_stack_tag, 19);
    chk("b2b_push", bus.ret_push_num, 0);
    tick();
    idle();
    #1;
    chk("b2b_ret_pc", bus.ret_pc, 16'h0123);
    chk("b2b_ret_vld", bus.ret_pc_vld, 1);

    // Local count saturates at 255
    drive_call(9'd250, 8'd200, 8'd100, 1'b0, 16'h0200);
    tick();
    idle();
    bus.local_idx = 8'd254;
    #1;
    chk("sat_laddr", bus.l_addr, 304);
    chk("sat_oob_254", bus.local_oob, 0);
    bus.local_idx = 8'd255;
    #1;
    chk("sat_oob_255", bus.local_oob, 1);

    // Frame overflow
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_call(9'd100, 8'd0, 8'd1, 1'b0, 16'(i));
      tick();
    end
    idle();
    #1;
    chk("full_depth", bus.depth, 16);
    chk("full_ready", bus.frame_ready, 1);
    drive_call(9'd100, 8'd0, 8'd1, 1'b0, 16'h0999);
    chk("ovf_alloc", bus.allocate_local_memory_size, 0);
    tick();
    idle();
    #1;
    chk("ovf_trap", bus.trap, 1);
    chk("ovf_code", bus.trap_code, 1);
    chk("ovf_depth", bus.depth, 16);
    chk("ovf_ready", bus.frame_ready, 0);
    drive_ret();
    tick();
    idle();
    #1;
    chk("trap_ret_ign", bus.depth, 16);
    chk("trap_vld_ign", bus.ret_pc_vld, 0);

    // Operand underflow
    do_reset();
    drive_call(9'd1, 8'd2, 8'd1, 1'b0, 16'h0050);
    chk("unf_alloc", bus.allocate_local_memory_size, 0);
    tick();
    idle();
    #1;
    chk("unf_trap", bus.trap, 1);
    chk("unf_code", bus.trap_code, 2);
    chk("unf_depth", bus.depth, 0);

    // Call and return together
    do_reset();
    drive_call(9'd30, 8'd0, 8'd2, 1'b0, 16'h0060);
    tick();
    drive_call(9'd30, 8'd0, 8'd2, 1'b0, 16'h0061);
    bus.ret_req = 1'b1;
    #1;
    chk("cr_alloc", bus.allocate_local_memory_size, 0);
    tick();
    idle();
    #1;
    chk("cr_code", bus.trap_code, 3);
    chk("cr_depth", bus.depth, 1);
    chk("cr_state", dbg_state, ST_TRAP);

    // Reset while nested with a call presented
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_call(9'd50, 8'd2, 8'd1, 1'b1, 16'h0100 + 16'(i));
      tick();
    end
    idle();
    #1;
    chk("nest_depth", bus.depth, 5);
    chk("nest_base", bus.function_stack_tag, 48);
    drive_call(9'd50, 8'd2, 8'd1, 1'b1, 16'h0777);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("mid_rst_depth", bus.depth, 0);
    chk("mid_rst_trap", bus.trap, 0);
    chk("mid_rst_halt", bus.halt, 0);
    chk("mid_rst_base", bus.function_stack_tag, 0);
    chk("mid_rst_ready", bus.frame_ready, 1);
    chk("mid_rst_oob", bus.local_oob, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
